// File: rtl/redun_to_bin.sv
// Redundant-to-canonical output stage: word-serial carry propagation, then
// bounded conditional subtraction of P. Optional counters under REDUN_TO_BIN_STATS_EN.

package redun_mont_pkg;
    localparam int NUM_WRDS = 4;
    localparam int WRD_BITS = 16;
    localparam logic [NUM_WRDS*WRD_BITS-1:0] P = 64'hFFFF_FFFF_FFFF_FFC5;
endpackage

module redun_to_bin #(
    parameter int                           NUM_WRDS = redun_mont_pkg::NUM_WRDS,
    parameter int                           WRD_BITS = redun_mont_pkg::WRD_BITS,
    parameter logic [NUM_WRDS*WRD_BITS-1:0] P        = redun_mont_pkg::P,
    parameter int                           MAX_SUB  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [WRD_BITS:0]   i_dat [NUM_WRDS],
    input  logic                i_val,
    output logic                o_rdy,
    output logic                o_drop,
    output logic [WRD_BITS-1:0] o_dat [NUM_WRDS],
    output logic                o_val,
    input  logic                i_rdy,
    output logic                o_err
`ifdef REDUN_TO_BIN_STATS_EN
    ,
    output logic [31:0]         o_conv_cnt,
    output logic [31:0]         o_drop_cnt
`endif
);

    localparam int CW = NUM_WRDS * WRD_BITS;
    localparam int AW = CW + 2;
    localparam int IW = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
    localparam int SW = $clog2(MAX_SUB + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_WRDS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [SW-1:0] MAX_SUB_C = SW'(MAX_SUB);
    localparam logic [SW-1:0] SUB_ONE   = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CARRY  = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [WRD_BITS:0]   r_words [NUM_WRDS];
    logic [IW-1:0]       r_idx;
    logic [1:0]          r_carry;
    logic [SW-1:0]       r_sub_cnt;
    logic [AW-1:0]       r_acc;
    logic [WRD_BITS-1:0] r_dat [NUM_WRDS];
    logic                r_rdy;
    logic                r_val;
    logic                r_err;
    logic                r_drop;

    logic [WRD_BITS:0]   w_word;
    logic [WRD_BITS+1:0] w_sum;
    logic [AW-1:0]       w_p_ext;
    logic                w_ge;
    logic [AW-1:0]       w_diff;

    // Current-word carry add and full-width compare/subtract against P
    always_comb begin
        w_word  = r_words[r_idx];
        w_sum   = {1'b0, w_word} + {{WRD_BITS{1'b0}}, r_carry};
        w_p_ext = {2'b00, P};
        w_ge    = (r_acc >= w_p_ext);
        w_diff  = r_acc - w_p_ext;
    end

    // Control FSM with registered handshake, result and drop outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_carry   <= 2'b00;
            r_sub_cnt <= '0;
            r_acc     <= '0;
            r_rdy     <= 1'b1;
            r_val     <= 1'b0;
            r_err     <= 1'b0;
            r_drop    <= 1'b0;
            for (int i = 0; i < NUM_WRDS; i++) begin
                r_words[i] <= '0;
                r_dat[i]   <= '0;
            end
        end else begin
            // The squarer cannot stall, so anything offered while busy is lost
            r_drop <= i_val && !r_rdy;
            case (r_state)
                S_IDLE: begin
                    if (i_val) begin
                        r_words   <= i_dat;
                        r_idx     <= '0;
                        r_carry   <= 2'b00;
                        r_sub_cnt <= '0;
                        r_acc     <= '0;
                        r_rdy     <= 1'b0;
                        r_state   <= S_CARRY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CARRY: begin
                    r_acc[int'(r_idx)*WRD_BITS +: WRD_BITS] <= w_sum[WRD_BITS-1:0];
                    r_carry <= w_sum[WRD_BITS+1:WRD_BITS];
                    if (r_idx == LAST_IDX) begin
                        r_acc[AW-1:CW] <= w_sum[WRD_BITS+1:WRD_BITS];
                        r_state        <= S_REDUCE;
                    end else begin
                        r_idx <= r_idx + IDX_ONE;
                    end
                end
                S_REDUCE: begin
                    if (w_ge && (r_sub_cnt < MAX_SUB_C)) begin
                        r_acc     <= w_diff;
                        r_sub_cnt <= r_sub_cnt + SUB_ONE;
                    end else begin
                        for (int i = 0; i < NUM_WRDS; i++) begin
                            r_dat[i] <= r_acc[i*WRD_BITS +: WRD_BITS];
                        end
                        r_err   <= w_ge;
                        r_val   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_rdy) begin
                        r_val   <= 1'b0;
                        r_err   <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rdy   <= 1'b1;
                    r_val   <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign o_rdy  = r_rdy;
    assign o_val  = r_val;
    assign o_err  = r_err;
    assign o_drop = r_drop;
    assign o_dat  = r_dat;

`ifdef REDUN_TO_BIN_STATS_EN
    logic [31:0] r_conv_cnt;
    logic [31:0] r_drop_cnt;

    // Wrapping event counters for completed handshakes and dropped inputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_conv_cnt <= 32'd0;
            r_drop_cnt <= 32'd0;
        end else begin
            if ((r_state == S_DONE) && i_rdy) begin
                r_conv_cnt <= r_conv_cnt + 32'd1;
            end else begin
                r_conv_cnt <= r_conv_cnt;
            end
            if (i_val && !r_rdy) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    assign o_conv_cnt = r_conv_cnt;
    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_redun_to_bin.sv
// Scoreboard bench for redun_to_bin: a value-level model predicts residue,
// error flag and latency; a second instance runs with MAX_SUB=1.
`timescale 1ns/1ps
module tb_redun_to_bin;
    localparam int NW = 4;
    localparam int W  = 16;
    localparam int MS = 4;
    localparam logic [63:0] PM = 64'hFFFF_FFFF_FFFF_FFC5;

    typedef struct {
        logic [63:0] dat;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, val, rdy, val2, rdy2;
    logic [W:0]   dat [NW];
    logic         o_rdy, o_drop, o_val, o_err;
    logic [W-1:0] o_dat [NW];
    logic         o_rdy2, o_drop2, o_val2, o_err2;
    logic [W-1:0] o_dat2 [NW];
    logic [31:0]  conv_cnt, drop_cnt, conv_cnt2, drop_cnt2;
    wire  [63:0]  got  = {o_dat[3],  o_dat[2],  o_dat[1],  o_dat[0]};
    wire  [63:0]  got2 = {o_dat2[3], o_dat2[2], o_dat2[1], o_dat2[0]};

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    redun_to_bin #(.NUM_WRDS(NW), .WRD_BITS(W), .P(PM), .MAX_SUB(MS)) dut (
        .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val), .o_rdy(o_rdy),
        .o_drop(o_drop), .o_dat(o_dat), .o_val(o_val), .i_rdy(rdy), .o_err(o_err)
`ifdef REDUN_TO_BIN_STATS_EN
        , .o_conv_cnt(conv_cnt), .o_drop_cnt(drop_cnt)
`endif
    );

    redun_to_bin #(.NUM_WRDS(NW), .WRD_BITS(W), .P(PM), .MAX_SUB(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val2), .o_rdy(o_rdy2),
        .o_drop(o_drop2), .o_dat(o_dat2), .o_val(o_val2), .i_rdy(rdy2), .o_err(o_err2)
`ifdef REDUN_TO_BIN_STATS_EN
        , .o_conv_cnt(conv_cnt2), .o_drop_cnt(drop_cnt2)
`endif
    );

    function automatic exp_t model(input logic [W:0] d [NW], input int maxsub);
        logic [65:0] v;
        exp_t        e;
        int          k;
        v = 66'd0;
        k = 0;
        for (int i = 0; i < NW; i++) v = v + (66'(d[i]) << (W * i));
        while ((v >= {2'b00, PM}) && (k < maxsub)) begin
            v = v - {2'b00, PM};
            k++;
        end
        e.dat = v[63:0];
        e.err = (v >= {2'b00, PM});
        e.lat = NW + k + 1;
        return e;
    endfunction

    task automatic drive(input logic [W:0] d [NW], input int maxsub, input bit second);
        int t;
        t = 0;
        while (!(second ? o_rdy2 : o_rdy) && (t < 50)) begin
            @(posedge clk); #1; t++;
        end
        dat = d;
        if (second) val2 = 1'b1; else val = 1'b1;
        sb.push_back(model(d, maxsub));
        @(posedge clk); #1;
        val  = 1'b0;
        val2 = 1'b0;
    endtask

    task automatic collect(input bit second, output logic [63:0] gd, output logic ge, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!(second ? o_val2 : o_val) && (lat < 60));
        if (!(second ? o_val2 : o_val)) lat = -1;
        gd = second ? got2 : got;
        ge = second ? o_err2 : o_err;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        val = 1'b0; val2 = 1'b0; rdy = 1'b1; rdy2 = 1'b1;
        for (int i = 0; i < NW; i++) dat[i] = '0;
        do_reset();
        n_tests++;
        if (o_rdy !== 1'b1 || o_val !== 1'b0 || o_err !== 1'b0 || o_drop !== 1'b0 || got !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b val=%b err=%b drop=%b dat=%h, expected 1 0 0 0 0",
                     o_rdy, o_val, o_err, o_drop, got);
        end
    endtask

    task automatic test_carry_only();
        logic [W:0]  w [NW];
        logic [63:0] gd;
        logic        ge;
        int          lat;
        exp_t        e;
        w = '{17'h10000, 17'h0, 17'h0, 17'h0};
        drive(w, MS, 1'b0);
        collect(1'b0, gd, ge, lat);
        e = sb.pop_front();
        n_tests++;
        if (gd !== 64'h0000_0000_0001_0000 || gd !== e.dat || ge !== e.err || lat !== 5) begin
            n_fail++;
            $display("FAIL carry_only: dat=%h err=%b lat=%0d, expected dat=%h err=%b lat=5",
                     gd, ge, lat, e.dat, e.err);
        end
    endtask

    task automatic test_exact_modulus();
        logic [W:0]  w [NW];
        logic [63:0] gd;
        logic        ge;
        int          lat;
        exp_t        e;
        w = '{17'h0FFC5, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF};
        drive(w, MS, 1'b0);
        collect(1'b0, gd, ge, lat);
        e = sb.pop_front();
        n_tests++;
        if (gd !== 64'd0 || ge !== 1'b0 || lat !== e.lat || lat !== 6) begin
            n_fail++;
            $display("FAIL exact_modulus: dat=%h err=%b lat=%0d, expected dat=0 err=0 lat=6", gd, ge, lat);
        end
    endtask

    task automatic test_double_reduction();
        logic [W:0]  w [NW];
        logic [63:0] gd;
        logic        ge;
        int          lat;
        exp_t        e;
        w = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        drive(w, MS, 1'b0);
        collect(1'b0, gd, ge, lat);
        e = sb.pop_front();
        n_tests++;
        if (gd !== 64'h0001_0001_0001_0075 || gd !== e.dat || ge !== 1'b0 || lat !== 7) begin
            n_fail++;
            $display("FAIL double_reduction: dat=%h err=%b lat=%0d, expected dat=0001000100010075 err=0 lat=7",
                     gd, ge, lat);
        end
        drive(w, 1, 1'b1);
        collect(1'b1, gd, ge, lat);
        e = sb.pop_front();
        n_tests++;
        if (gd !== e.dat || ge !== 1'b1 || e.err !== 1'b1 || lat !== 6) begin
            n_fail++;
            $display("FAIL max_sub_1: dat=%h err=%b lat=%0d, expected dat=%h err=1 lat=6", gd, ge, lat, e.dat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0]  w [NW];
        logic [63:0] gd;
        logic        ge;
        int          lat;
        exp_t        e;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NW; i++) w[i] = 17'($urandom_range(0, 32'h1FFFF));
            if (n == 0) w = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
            drive(w, MS, 1'b0);
            collect(1'b0, gd, ge, lat);
            e = sb.pop_front();
            n_tests++;
            if (gd !== e.dat || ge !== e.err || lat !== e.lat) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: dat=%h err=%b lat=%0d, expected dat=%h err=%b lat=%0d",
                         n, gd, ge, lat, e.dat, e.err, e.lat);
            end
            @(posedge clk); #1;
            n_tests++;
            if (o_rdy !== 1'b1 || o_val !== 1'b0) begin
                n_fail++;
                $display("FAIL back_to_back_rdy[%0d]: rdy=%b val=%b, expected rdy=1 val=0", n, o_rdy, o_val);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W:0]  w [NW];
        logic [63:0] gd;
        logic        ge;
        int          lat;
        int          drops;
        bit          stable;
        exp_t        e;
        do_reset();
        rdy = 1'b0;
        w = '{17'h10000, 17'h00003, 17'h1ABCD, 17'h00042};
        drive(w, MS, 1'b0);
        collect(1'b0, gd, ge, lat);
        e = sb.pop_front();
        n_tests++;
        if (gd !== e.dat || ge !== e.err || lat !== e.lat) begin
            n_fail++;
            $display("FAIL bp_result: dat=%h err=%b lat=%0d, expected dat=%h err=%b lat=%0d",
                     gd, ge, lat, e.dat, e.err, e.lat);
        end
        drops  = 0;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) val = 1'b1;
            @(posedge clk); #1;
            val = 1'b0;
            if (got !== gd || o_val !== 1'b1 || o_rdy !== 1'b0 || o_err !== ge) stable = 1'b0;
            if (o_drop === 1'b1) drops++;
        end
        n_tests++;
        if (!stable || drops != 1) begin
            n_fail++;
            $display("FAIL bp_hold: stable=%b drops=%0d, expected stable=1 drops=1", stable, drops);
        end
`ifdef REDUN_TO_BIN_STATS_EN
        n_tests++;
        if (drop_cnt !== 32'd1 || conv_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL bp_stats_hold: drop_cnt=%0d conv_cnt=%0d, expected 1 0", drop_cnt, conv_cnt);
        end
`endif
        rdy = 1'b1;
        val = 1'b1;
        @(posedge clk); #1;
        val = 1'b0;
        n_tests++;
        if (o_rdy !== 1'b1 || o_val !== 1'b0 || o_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b val=%b drop=%b, expected 1 0 1", o_rdy, o_val, o_drop);
        end
        @(posedge clk); #1;
        n_tests++;
        if (o_rdy !== 1'b1 || o_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_not_accepted: rdy=%b drop=%b, expected 1 0", o_rdy, o_drop);
        end
`ifdef REDUN_TO_BIN_STATS_EN
        n_tests++;
        if (drop_cnt !== 32'd2 || conv_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_stats_release: drop_cnt=%0d conv_cnt=%0d, expected 2 1", drop_cnt, conv_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_carry();
        logic [W:0]  w [NW];
        logic [63:0] gd;
        logic        ge;
        int          lat;
        bit          seen;
        exp_t        e;
        w = '{17'h1FFFF, 17'h12345, 17'h0FFFF, 17'h1FFFF};
        drive(w, MS, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_front());
        n_tests++;
        if (o_rdy !== 1'b1 || o_val !== 1'b0 || o_err !== 1'b0 || o_drop !== 1'b0 || got !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_reset_state: rdy=%b val=%b err=%b drop=%b dat=%h, expected 1 0 0 0 0",
                     o_rdy, o_val, o_err, o_drop, got);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (o_val === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_reset_no_val: o_val rose=%b, expected 0", seen);
        end
        w = '{17'h10000, 17'h0, 17'h0, 17'h0};
        drive(w, MS, 1'b0);
        collect(1'b0, gd, ge, lat);
        e = sb.pop_front();
        n_tests++;
        if (gd !== 64'h0000_0000_0001_0000 || gd !== e.dat || ge !== 1'b0 || lat !== 5) begin
            n_fail++;
            $display("FAIL mid_reset_recover: dat=%h err=%b lat=%0d, expected dat=10000 err=0 lat=5", gd, ge, lat);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_carry_only();
        test_exact_modulus();
        test_double_reduction();
        test_back_to_back();
        test_reset_mid_carry();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/redun_to_bin.md
Name: redun_to_bin

Overview:
- Output stage directly downstream of the redundant-form Montgomery squarer.
- Accepts one redundant result: NUM_WRDS words of WRD_BITS+1 bits each, where word i has weight 2^(i*WRD_BITS).
- Propagates the carries word-serially, then reduces to the canonical residue in [0, P) by repeated conditional subtraction of P.
- Presents the residue as NUM_WRDS canonical WRD_BITS-bit words with a valid/ready handshake toward the host/readback logic.

Parameters:
- NUM_WRDS, redun_mont_pkg::NUM_WRDS, number of words.
- WRD_BITS, redun_mont_pkg::WRD_BITS, canonical bits per word; redundant words carry one extra bit.
- P, redun_mont_pkg::P, modulus; NUM_WRDS*WRD_BITS bits.
- MAX_SUB, 4, maximum number of P subtractions before an error is flagged.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_dat  in  [WRD_BITS:0] x NUM_WRDS  redundant input words
- i_val  in  1  input valid
- o_rdy  out  1  block idle and able to accept
- o_drop  out  1  one-cycle pulse: i_val was seen while o_rdy=0, and that input is discarded
- o_dat  out  [WRD_BITS-1:0] x NUM_WRDS  canonical residue words
- o_val  out  1  result valid; held until consumed
- i_rdy  in  1  downstream ready
- o_err  out  1  qualified by o_val: the result was still >= P after MAX_SUB subtractions

Behaviour:
- Reset values: o_rdy=1, o_val=0, o_err=0, o_drop=0, o_dat=0. Internal state is cleared: state=IDLE, idx=0, sub_cnt=0, accumulator=0, carry=0.
- The accumulator is NUM_WRDS*WRD_BITS+2 bits wide.
- States:
  - IDLE, o_rdy=1: on i_val, capture i_dat, clear idx/carry/sub_cnt/accumulator, and go to CARRY.
  - CARRY, one edge per word, idx 0..NUM_WRDS-1:
    - s = word[idx] + carry, with carry 2 bits wide (max value 2).
    - acc word idx <= s[WRD_BITS-1:0]; carry <= s>>WRD_BITS.
    - After word NUM_WRDS-1, place the final carry in acc bits [NW*W+1:NW*W] and go to REDUCE.
  - REDUCE, one comparison per edge:
    - If acc >= P and sub_cnt < MAX_SUB: acc <= acc-P, sub_cnt++.
    - Else: o_dat <= acc[NW*W-1:0]; o_err <= (acc >= P); o_val <= 1; go to DONE.
  - DONE: hold o_dat, o_val and o_err stable while i_rdy=0. On o_val&&i_rdy: clear o_val and o_err, go to IDLE, o_rdy <= 1.
- o_rdy is registered and low in CARRY, REDUCE and DONE.
  - The upstream squarer has no backpressure.
  - i_val with o_rdy=0: o_drop pulses high on the following cycle and state is unaffected.
- Latency: with k subtractions, o_val rises exactly NUM_WRDS+k+1 edges after the accepting edge. The minimum throughput interval is NUM_WRDS+k+3 cycles with i_rdy held high.
- Simultaneous i_val and handshake completion in DONE: the input is dropped (o_drop). A new input is accepted only when o_rdy=1.
- Reset asserted mid-operation: the cycle after reset, all outputs are at their reset values. Any partial result is discarded and no o_val is produced.
- All arithmetic is unsigned. The comparison and subtraction are full-width combinational over the accumulator.

Optional Feature:
- Macro REDUN_TO_BIN_STATS_EN.
- When defined, adds two outputs, both cleared by i_rst and wrapping mod 2^32:
  - o_conv_cnt [31:0]: increments on each completed o_val&&i_rdy handshake.
  - o_drop_cnt [31:0]: increments on each o_drop pulse.
- When undefined, these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
All scenarios use NUM_WRDS=4, WRD_BITS=16, P=0xFFFF_FFFF_FFFF_FFC5, MAX_SUB=4 unless stated.
- Carry only: words {0x10000,0,0,0} (word0 first), i_rdy=1 -> o_dat=0x0000_0000_0001_0000, o_err=0, o_val 5 edges after accept.
- Exact modulus: words {0xFFC5,0xFFFF,0xFFFF,0xFFFF} -> o_dat=0, k=1, o_val 6 edges after accept.
- Double reduction: all words 0x1FFFF -> o_dat=0x0001_0001_0001_0075, k=2, o_val at 7 edges, o_err=0.
  - Repeat with MAX_SUB=1 -> o_val at 6 edges, o_err=1.
- Backpressure/drop:
  - Hold i_rdy=0 for 10 cycles after o_val -> o_dat stable and o_rdy=0 throughout.
  - Pulse i_val during DONE -> o_drop pulses once; with REDUN_TO_BIN_STATS_EN, o_drop_cnt=1.
  - Release i_rdy -> o_rdy=1 next cycle; with REDUN_TO_BIN_STATS_EN, o_conv_cnt=1.
- Reset mid-CARRY: assert i_rst 2 edges after accept -> o_val never rises. A following input {0x10000,0,0,0} yields the correct result at 5 edges.
